// File: rtl/sum_stationary_stream_pkg.sv
// Shared types and helpers for the output-stationary systolic multiplier.
//   state_t       : job FSM states (IDLE, LOAD, FLUSH, DRAIN)
//   c_data_width(): default accumulator width for a given operand width and
//                   maximum inner dimension (product width + growth bits).
package sum_stationary_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic int c_data_width(input int data_width, input int k_max);
        return 2 * data_width + $clog2(k_max);
    endfunction

endpackage

// File: rtl/sum_stationary_stream_mac.sv
// Single processing element of the output-stationary array.
// Ports:
//   clk, reset_i : clock, synchronous active-high reset
//   en_i         : array enable; advances operand registers and accumulator
//   clr_i        : clears operand registers and accumulator (job start)
//   signed_i     : 1 = operands are two's complement, 0 = unsigned
//   a_i / b_i    : operands arriving from the west / north neighbour
//   a_o / b_o    : registered pass-through to the east / south neighbour
//   acc_o        : registered accumulator (one element of C)
module mac_pe
    import sum_stationary_stream_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int C_DATA_WIDTH = 20
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic                    en_i,
    input  logic                    clr_i,
    input  logic                    signed_i,
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic [DATA_WIDTH-1:0]   a_o,
    output logic [DATA_WIDTH-1:0]   b_o,
    output logic [C_DATA_WIDTH-1:0] acc_o
);

    logic [DATA_WIDTH-1:0]          a_q, a_d;
    logic [DATA_WIDTH-1:0]          b_q, b_d;
    logic [C_DATA_WIDTH-1:0]        acc_q, acc_d;

    logic signed [DATA_WIDTH:0]     a_ext, b_ext;
    logic signed [C_DATA_WIDTH-1:0] prod_ext;

    // One extra bit carries the sign in signed mode and is zero otherwise, so
    // a single signed multiplier serves both modes.
    assign a_ext = {signed_i & a_i[DATA_WIDTH-1], a_i};
    assign b_ext = {signed_i & b_i[DATA_WIDTH-1], b_i};

    // Multiplying the sign-extended operands at full accumulator width gives
    // the product already extended and reduced modulo 2^C_DATA_WIDTH.
    assign prod_ext = C_DATA_WIDTH'(a_ext) * C_DATA_WIDTH'(b_ext);

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (clr_i) begin
            a_d   = '0;
            b_d   = '0;
            acc_d = '0;
        end else if (en_i) begin
            a_d   = a_i;
            b_d   = b_i;
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/sum_stationary_stream.sv
// Output-stationary NxN systolic multiplier computing C = A*B, A is N x K,
// B is K x N, K chosen per job (1..K_MAX), signed or unsigned per job.
// Ports:
//   clk, reset_i   : clock, synchronous active-high reset (aborts any job)
//   start_i        : job start, honoured in IDLE only; samples k_len_i, signed_i
//   k_len_i        : inner dimension K (0 or > K_MAX ignores the start)
//   signed_i       : 1 = two's-complement operands
//   in_valid_i/in_ready_o : operand beat handshake; a_i = column m of A,
//                    b_i = row m of B
//   out_valid_o/out_ready_i : result handshake; out_row_o = row r of C,
//                    out_row_idx_o = r
//   busy_o         : high whenever a job is in progress
// Handshake rule (both ports): a beat transfers on a rising clock edge where
// valid and ready are both high. The producer holds data stable while valid is
// high and ready is low; ready never depends on valid.
module sum_stationary_stream
    import sum_stationary_stream_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int K_MAX        = 16,
    parameter int C_DATA_WIDTH = c_data_width(DATA_WIDTH, K_MAX),
    parameter int KW           = $clog2(K_MAX + 1)
) (
    input  logic                             clk,
    input  logic                             reset_i,
    input  logic                             start_i,
    input  logic [KW-1:0]                    k_len_i,
    input  logic                             signed_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [N-1:0][DATA_WIDTH-1:0]     a_i,
    input  logic [N-1:0][DATA_WIDTH-1:0]     b_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [N-1:0][C_DATA_WIDTH-1:0]   out_row_o,
    output logic [$clog2(N)-1:0]             out_row_idx_o,
    output logic                             busy_o
);

    localparam int RW = $clog2(N);
    localparam int FW = $clog2(2 * N - 1);

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            signed_q, signed_d;
    logic [KW-1:0]   beat_q, beat_d;
    logic [FW-1:0]   flush_q, flush_d;
    logic [RW-1:0]   row_q, row_d;

    logic            en;
    logic            clr;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        signed_d    = signed_q;
        beat_d      = beat_q;
        flush_d     = flush_q;
        row_d       = row_q;
        en          = 1'b0;
        clr         = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && (k_len_i != '0) && (k_len_i <= KW'(K_MAX))) begin
                    state_d  = LOAD;
                    k_d      = k_len_i;
                    signed_d = signed_i;
                    beat_d   = '0;
                    clr      = 1'b1;
                end
            end
            LOAD: begin
                in_ready_o = 1'b1;
                // A missing beat freezes the whole array, keeping skew aligned.
                if (in_valid_i) begin
                    en = 1'b1;
                    if (beat_q == k_q - KW'(1)) begin
                        beat_d  = '0;
                        flush_d = '0;
                        state_d = FLUSH;
                    end else begin
                        beat_d = beat_q + KW'(1);
                    end
                end
            end
            FLUSH: begin
                // 2N-2 zero cycles push the last term through to PE(N-1,N-1).
                en = 1'b1;
                if (flush_q == FW'(2 * N - 3)) begin
                    state_d = DRAIN;
                    row_d   = '0;
                end else begin
                    flush_d = flush_q + FW'(1);
                end
            end
            DRAIN: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    if (row_q == RW'(N - 1)) begin
                        state_d = IDLE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q  <= IDLE;
            k_q      <= '0;
            signed_q <= 1'b0;
            beat_q   <= '0;
            flush_q  <= '0;
            row_q    <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            signed_q <= signed_d;
            beat_q   <= beat_d;
            flush_q  <= flush_d;
            row_q    <= row_d;
        end
    end

    assign busy_o = (state_q != IDLE);

    // ---------------------------------------------------------- skew chains
    // Zeros are injected outside LOAD so flush cycles contribute nothing.
    logic [DATA_WIDTH-1:0] a_feed [N];
    logic [DATA_WIDTH-1:0] b_feed [N];
    logic [DATA_WIDTH-1:0] a_skew [N];
    logic [DATA_WIDTH-1:0] b_skew [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_feed[i] = (state_q == LOAD) ? a_i[i] : '0;
            b_feed[i] = (state_q == LOAD) ? b_i[i] : '0;
        end
    end

    // Lane i (row i of A, column i of B) is delayed by i enabled cycles.
    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_skew[i] = a_feed[i];
            assign b_skew[i] = b_feed[i];
        end else begin : g_chain
            logic [DATA_WIDTH-1:0] a_chain_q [i];
            logic [DATA_WIDTH-1:0] b_chain_q [i];

            always_ff @(posedge clk) begin
                if (reset_i || clr) begin
                    for (int k = 0; k < i; k++) begin
                        a_chain_q[k] <= '0;
                        b_chain_q[k] <= '0;
                    end
                end else if (en) begin
                    a_chain_q[0] <= a_feed[i];
                    b_chain_q[0] <= b_feed[i];
                    for (int k = 1; k < i; k++) begin
                        a_chain_q[k] <= a_chain_q[k-1];
                        b_chain_q[k] <= b_chain_q[k-1];
                    end
                end
            end

            assign a_skew[i] = a_chain_q[i-1];
            assign b_skew[i] = b_chain_q[i-1];
        end
    end

    // ------------------------------------------------------------ PE grid
    logic [DATA_WIDTH-1:0]   a_out [N][N];
    logic [DATA_WIDTH-1:0]   b_out [N][N];
    logic [C_DATA_WIDTH-1:0] acc   [N][N];

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DATA_WIDTH-1:0] a_west;
            logic [DATA_WIDTH-1:0] b_north;

            if (j == 0) begin : g_a_edge
                assign a_west = a_skew[i];
            end else begin : g_a_inner
                assign a_west = a_out[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_north = b_skew[j];
            end else begin : g_b_inner
                assign b_north = b_out[i-1][j];
            end

            mac_pe #(
                .DATA_WIDTH  (DATA_WIDTH),
                .C_DATA_WIDTH(C_DATA_WIDTH)
            ) u_pe (
                .clk     (clk),
                .reset_i (reset_i),
                .en_i    (en),
                .clr_i   (clr),
                .signed_i(signed_q),
                .a_i     (a_west),
                .b_i     (b_north),
                .a_o     (a_out[i][j]),
                .b_o     (b_out[i][j]),
                .acc_o   (acc[i][j])
            );
        end
    end

    // Operands leaving the east and south edges have no consumer.
    logic [N-1:0] unused_edge;
    for (genvar i = 0; i < N; i++) begin : g_edge
        assign unused_edge[i] = ^{a_out[i][N-1], b_out[N-1][i]};
    end

    // ------------------------------------------------------------- output
    always_comb begin
        for (int j = 0; j < N; j++) begin
            out_row_o[j] = acc[row_q][j];
        end
    end

    assign out_row_idx_o = row_q;

endmodule

// File: tb/tb_sum_stationary_stream.sv
module tb_sum_stationary_stream;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int KM = 16;
  localparam int CW = 2 * DW + $clog2(KM);
  localparam int KW = $clog2(KM + 1);
  localparam int RW = N * CW;

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic reset_i;
  logic start_i;
  logic [KW-1:0] k_len_i;
  logic signed_i;
  logic in_valid_i;
  logic in_ready_o;
  logic [N-1:0][DW-1:0] a_i;
  logic [N-1:0][DW-1:0] b_i;
  logic out_valid_o;
  logic out_ready_i;
  logic [N-1:0][CW-1:0] out_row_o;
  logic [$clog2(N)-1:0] out_row_idx_o;
  logic busy_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sum_stationary_stream #(
    .DATA_WIDTH(DW),
    .N(N),
    .K_MAX(KM)
  ) dut (
    .clk(clk),
    .reset_i(reset_i),
    .start_i(start_i),
    .k_len_i(k_len_i),
    .signed_i(signed_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .a_i(a_i),
    .b_i(b_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_row_o(out_row_o),
    .out_row_idx_o(out_row_idx_o),
    .busy_o(busy_o)
  );

  // ------------------------------------------------------------ scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [RW-1:0] exp_q[$];
  logic [DW-1:0] a_mat [N][KM];
  logic [DW-1:0] b_mat [KM][N];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint val(input logic [DW-1:0] x, input bit s);
    return s ? longint'($signed(x)) : longint'(x);
  endfunction

  // Reference: C[i][j] = sum_m A[i][m]*B[m][j], reduced modulo 2^CW.
  task automatic push_model(input int k, input bit s);
    logic [RW-1:0] row;
    longint sum;
    for (int i = 0; i < N; i++) begin
      row = '0;
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int m = 0; m < k; m++) sum += val(a_mat[i][m], s) * val(b_mat[m][j], s);
        row[j*CW +: CW] = sum[CW-1:0];
      end
      exp_q.push_back(row);
    end
  endtask

  task automatic push_const_rows(input logic [CW-1:0] c);
    logic [RW-1:0] row;
    for (int j = 0; j < N; j++) row[j*CW +: CW] = c;
    for (int i = 0; i < N; i++) exp_q.push_back(row);
  endtask

  // ------------------------------------------------------------ drivers
  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    in_valid_i = 1'b0;
    start_i = 1'b0;
    out_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  // Start cycle also presents a junk beat that must not be accepted.
  task automatic do_start(input int k, input bit s);
    @(negedge clk);
    start_i = 1'b1;
    k_len_i = KW'(k);
    signed_i = s;
    in_valid_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_i[i] = DW'($urandom);
      b_i[i] = DW'($urandom);
    end
    @(negedge clk);
    start_i = 1'b0;
    in_valid_i = 1'b0;
  endtask

  task automatic feed(input int k, input int bubble_pct, input bit noise, output int t0);
    int m = 0;
    int guard = 0;
    t0 = -1;
    while (m < k && guard < 400) begin
      if ($urandom_range(99) < bubble_pct) begin
        in_valid_i = 1'b0;
        for (int i = 0; i < N; i++) begin
          a_i[i] = DW'($urandom);
          b_i[i] = DW'($urandom);
        end
      end else begin
        in_valid_i = 1'b1;
        for (int i = 0; i < N; i++) begin
          a_i[i] = a_mat[i][m];
          b_i[i] = b_mat[m][i];
        end
      end
      start_i = noise ? 1'($urandom_range(1)) : 1'b0;
      k_len_i = KW'($urandom_range(KM));
      signed_i = 1'($urandom_range(1));
      if (in_valid_i && in_ready_o) begin
        if (m == 0) t0 = cyc;
        m++;
      end
      guard++;
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    start_i = 1'b0;
    check("feed_beats", m, k);
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low for 5 cycles at row 1
  task automatic drain(input int mode, input bit noise, output int t_valid, output int t_last);
    int r = 0;
    int guard = 0;
    int stall = 0;
    bit rdy;
    t_valid = -1;
    t_last = -1;
    while (r < N && guard < 400) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(1));
        default: rdy = !(r == 1 && stall < 5);
      endcase
      out_ready_i = rdy;
      start_i = noise ? 1'($urandom_range(1)) : 1'b0;
      k_len_i = KW'($urandom_range(KM));
      if (out_valid_o) begin
        if (t_valid < 0) t_valid = cyc;
        check("busy_in_drain", busy_o, 1);
        check("row_data", out_row_o, (exp_q.size() > 0) ? exp_q[0] : 'x);
        check("row_idx", out_row_idx_o, r);
        if (rdy) begin
          void'(exp_q.pop_front());
          t_last = cyc;
          r++;
        end else begin
          stall++;
        end
      end
      guard++;
      @(negedge clk);
    end
    out_ready_i = 1'b0;
    start_i = 1'b0;
    check("drain_rows", r, N);
    check("idle_after_drain", {busy_o, out_valid_o, in_ready_o}, 0);
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct {
    int k;
    bit s;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [CW-1:0] c;
  } vec_t;

  vec_t vecs[7];

  task automatic fill_identity();
    for (int i = 0; i < N; i++)
      for (int m = 0; m < KM; m++) a_mat[i][m] = (i == m) ? 8'd1 : 8'd0;
    for (int m = 0; m < KM; m++)
      for (int j = 0; j < N; j++) b_mat[m][j] = DW'(4 * m + j + 1);
  endtask

  task automatic push_identity_rows();
    logic [RW-1:0] row;
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) row[j*CW +: CW] = CW'(4 * r + j + 1);
      exp_q.push_back(row);
    end
  endtask

  initial begin
    int t0, tv, tl;
    int k;
    bit s;
    logic [RW-1:0] row;

    vecs[0] = '{16, 1'b1, 8'hFF, 8'h01, 20'hFFFF0};
    vecs[1] = '{16, 1'b0, 8'hFF, 8'h01, 20'd4080};
    vecs[2] = '{16, 1'b1, 8'h80, 8'h80, 20'h40000};
    vecs[3] = '{16, 1'b0, 8'hFF, 8'hFF, 20'hFE010};
    vecs[4] = '{1, 1'b1, 8'h7F, 8'h81, 20'hFC0FF};
    vecs[5] = '{3, 1'b0, 8'h02, 8'h03, 20'd18};
    vecs[6] = '{16, 1'b1, 8'h80, 8'h7F, 20'hC0800};

    reset_i = 1'b1;
    start_i = 1'b0;
    k_len_i = '0;
    signed_i = 1'b0;
    in_valid_i = 1'b0;
    a_i = '0;
    b_i = '0;
    out_ready_i = 1'b0;

    // Reset state
    do_reset();
    check("rst_in_ready", in_ready_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_out_row", out_row_o, 0);
    check("rst_out_idx", out_row_idx_o, 0);

    // Identity, unsigned, no stalls: latency check
    fill_identity();
    push_identity_rows();
    do_start(4, 1'b0);
    feed(4, 0, 1'b0, t0);
    drain(0, 1'b0, tv, tl);
    check("latency_first_valid", tv - t0, 4 + 2 * N - 2);
    check("latency_last_row", tl - t0, 4 + 3 * N - 3);

    // Same job with input bubbles and random output readiness
    push_identity_rows();
    do_start(4, 1'b0);
    feed(4, 40, 1'b0, t0);
    drain(1, 1'b0, tv, tl);

    // Output backpressure at row 1, with starts attempted during LOAD/DRAIN
    push_identity_rows();
    do_start(4, 1'b0);
    feed(4, 0, 1'b1, t0);
    drain(2, 1'b1, tv, tl);

    // Constant-fill table: sign mode and wrap corners
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < N; i++)
        for (int m = 0; m < KM; m++) a_mat[i][m] = vecs[v].a;
      for (int m = 0; m < KM; m++)
        for (int j = 0; j < N; j++) b_mat[m][j] = vecs[v].b;
      push_const_rows(vecs[v].c);
      do_start(vecs[v].k, vecs[v].s);
      feed(vecs[v].k, 20, 1'b1, t0);
      drain(1, 1'b1, tv, tl);
    end

    // Reset mid-job after 2 beats
    for (int i = 0; i < N; i++)
      for (int m = 0; m < KM; m++) a_mat[i][m] = DW'($urandom);
    for (int m = 0; m < KM; m++)
      for (int j = 0; j < N; j++) b_mat[m][j] = DW'($urandom);
    do_start(4, 1'b1);
    feed(2, 0, 1'b0, t0);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("abort_in_ready", in_ready_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_out_valid", out_valid_o, 0);
    check("abort_out_row", out_row_o, 0);
    for (int i = 0; i < N; i++) a_mat[i][0] = DW'(i + 1);
    for (int j = 0; j < N; j++) b_mat[0][j] = 8'd1;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) row[j*CW +: CW] = CW'(i + 1);
      exp_q.push_back(row);
    end
    do_start(1, 1'b0);
    feed(1, 0, 1'b0, t0);
    drain(0, 1'b0, tv, tl);

    // Ignored starts in IDLE
    @(negedge clk);
    start_i = 1'b1;
    k_len_i = '0;
    @(negedge clk);
    check("start_k0_busy", busy_o, 0);
    k_len_i = KW'(KM + 1);
    @(negedge clk);
    check("start_k17_busy", busy_o, 0);
    check("start_k17_ready", in_ready_o, 0);
    k_len_i = KW'(31);
    @(negedge clk);
    check("start_k31_busy", busy_o, 0);
    start_i = 1'b0;

    // Randomized jobs against the reference model
    for (int t = 0; t < 10; t++) begin
      k = $urandom_range(KM, 1);
      s = 1'($urandom_range(1));
      for (int i = 0; i < N; i++)
        for (int m = 0; m < KM; m++) a_mat[i][m] = DW'($urandom);
      for (int m = 0; m < KM; m++)
        for (int j = 0; j < N; j++) b_mat[m][j] = DW'($urandom);
      push_model(k, s);
      do_start(k, s);
      feed(k, 30, 1'b1, t0);
      drain(1, 1'b1, tv, tl);
    end

    check("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
